// File: rtl/variance_stream_mc.sv
// Multi-lane streaming mean / population-variance engine: accumulates INPUT_NUM
// beats of CHANNELS unsigned lanes, then emits per-lane mean and variance once per frame.
module variance_stream_mc #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int INPUT_NUM  = IMG_WIDTH * IMG_HEIGHT,
  parameter int LOG2_N     = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*WIDTH-1:0]      data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*WIDTH-1:0]      mean,
  output logic [CHANNELS*2*WIDTH-1:0]    variance,
  output logic [LOG2_N-1:0]              beat_count
);

  // Handshakes: a beat moves when in_valid && in_ready; a result is consumed
  // when out_valid && out_ready at a rising edge. in_ready is high only in ACCUM.

  localparam int SW = WIDTH + LOG2_N;
  localparam int QW = 2 * WIDTH + LOG2_N;
  localparam int VW = 2 * WIDTH;

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] CALC1 = 2'd1;
  localparam logic [1:0] CALC2 = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [LOG2_N-1:0] LAST_BEAT = LOG2_N'(INPUT_NUM - 1);

  generate
    if ((1 << LOG2_N) != INPUT_NUM) begin : g_bad_frame_size
      $error("variance_stream_mc: INPUT_NUM must equal 2**LOG2_N");
    end
  endgenerate

  logic [1:0]       state;
  logic [SW-1:0]    sum_acc   [CHANNELS];
  logic [QW-1:0]    sumsq_acc [CHANNELS];
  logic [WIDTH-1:0] mean_r    [CHANNELS];
  logic [VW-1:0]    ex2_r     [CHANNELS];
  logic [WIDTH-1:0] lane_x    [CHANNELS];
  logic [VW-1:0]    lane_sq   [CHANNELS];
  logic [VW-1:0]    mean_sq   [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      lane_x[c]  = data_in[c*WIDTH +: WIDTH];
      lane_sq[c] = VW'(lane_x[c]) * VW'(lane_x[c]);
      mean_sq[c] = VW'(mean_r[c]) * VW'(mean_r[c]);
    end
  end

  assign in_ready = (state == ACCUM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ACCUM;
      beat_count <= '0;
      out_valid  <= 1'b0;
      mean       <= '0;
      variance   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum_acc[c]   <= '0;
        sumsq_acc[c] <= '0;
        mean_r[c]    <= '0;
        ex2_r[c]     <= '0;
      end
    end else if (clear) begin
      // Frame abort: the last published result stays on mean/variance.
      state      <= ACCUM;
      beat_count <= '0;
      out_valid  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum_acc[c]   <= '0;
        sumsq_acc[c] <= '0;
      end
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
              sum_acc[c]   <= sum_acc[c] + SW'(lane_x[c]);
              sumsq_acc[c] <= sumsq_acc[c] + QW'(lane_sq[c]);
            end
            beat_count <= beat_count + LOG2_N'(1);
            if (beat_count == LAST_BEAT) state <= CALC1;
          end
        end
        CALC1: begin
          for (int c = 0; c < CHANNELS; c++) begin
            mean_r[c]    <= sum_acc[c][LOG2_N +: WIDTH];
            ex2_r[c]     <= sumsq_acc[c][LOG2_N +: VW];
            sum_acc[c]   <= '0;
            sumsq_acc[c] <= '0;
          end
          state <= CALC2;
        end
        CALC2: begin
          // floor(mean)^2 <= floor(E[x^2]), so the subtraction cannot underflow.
          for (int c = 0; c < CHANNELS; c++) begin
            mean[c*WIDTH +: WIDTH] <= mean_r[c];
            variance[c*VW +: VW]   <= ex2_r[c] - mean_sq[c];
          end
          out_valid <= 1'b1;
          state     <= OUT;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_variance_stream_mc.sv
// Self-checking bench for variance_stream_mc: random frames against an arithmetic
// reference model, plus directed latency, stall, clear and reset scenarios.
module tb_variance_stream_mc;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int N  = 64;
  localparam int LN = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [CH*W-1:0]   data_in;
  logic              out_valid;
  logic              out_ready;
  logic [CH*W-1:0]   mean;
  logic [CH*2*W-1:0] variance;
  logic [LN-1:0]     beat_count;

  int checks = 0;
  int errors = 0;

  logic [CH*W-1:0]   frame_data [N];
  logic [CH*W-1:0]   exp_mean;
  logic [CH*2*W-1:0] exp_var;

  variance_stream_mc dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mean       (mean),
    .variance   (variance),
    .beat_count (beat_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // mean = floor(sum / N); variance = floor(sum(x^2) / N) - mean^2
  task automatic model();
    longint s, q, m, v, x;
    for (int c = 0; c < CH; c++) begin
      s = 0;
      q = 0;
      for (int i = 0; i < N; i++) begin
        x = longint'(frame_data[i][c*W +: W]);
        s += x;
        q += x * x;
      end
      m = s / N;
      v = q / N - m * m;
      exp_mean[c*W +: W]     = W'(m);
      exp_var[c*2*W +: 2*W]  = (2*W)'(v);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int c = 0; c < CH; c++) frame_data[i][c*W +: W] = W'($urandom_range(255));
  endtask

  task automatic fill_const(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) frame_data[i] = {CH{v}};
  endtask

  task automatic fill_ramp();
    logic [W-1:0] alt;
    for (int i = 0; i < N; i++) begin
      alt = (i % 2 == 1) ? 8'd255 : 8'd0;
      frame_data[i] = {8'd0, 8'd255, alt, W'(i)};
    end
  endtask

  // Leaves the bench at edge k (+1) where k is the edge that took the last beat.
  task automatic send_frame(input int gap_pct);
    for (int i = 0; i < N; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        data_in  = $urandom;
        step();
      end
      in_valid = 1'b1;
      data_in  = frame_data[i];
      step();
      in_valid = 1'b0;
      data_in  = $urandom;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (beat_count !== '0) begin errors++; $display("FAIL reset_beat_count got %0d want 0", beat_count); end
    if (mean !== '0) begin errors++; $display("FAIL reset_mean got %h want 0", mean); end
    if (variance !== '0) begin errors++; $display("FAIL reset_variance got %h want 0", variance); end
  endtask

  task automatic test_constant();
    out_ready = 1'b1;
    fill_const(8'd5);
    model();
    send_frame(0);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL const_lat_k1 out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL const_busy in_ready got %b want 0", in_ready); end
    step();
    checks += 1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL const_lat_k2 out_valid got %b want 0", out_valid); end
    step();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL const_out_valid got %b want 1", out_valid); end
    if (mean !== {CH{8'd5}}) begin errors++; $display("FAIL const_mean got %h want %h", mean, {CH{8'd5}}); end
    if (variance !== '0) begin errors++; $display("FAIL const_var got %h want 0", variance); end
    step();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL const_one_cycle out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL const_back_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ramp_stall();
    logic [CH*W-1:0]   want_mean;
    logic [CH*2*W-1:0] want_var;
    want_mean = {8'd0, 8'd255, 8'd127, 8'd31};
    want_var  = {16'd0, 16'd0, 16'd16383, 16'd372};
    out_ready = 1'b0;
    fill_ramp();
    send_frame(0);
    step();
    step();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL ramp_out_valid got %b want 1", out_valid); end
    if (mean !== want_mean) begin errors++; $display("FAIL ramp_mean got %h want %h", mean, want_mean); end
    if (variance !== want_var) begin errors++; $display("FAIL ramp_var got %h want %h", variance, want_var); end
    for (int i = 0; i < 10; i++) begin
      data_in  = $urandom;
      in_valid = 1'(i % 2);
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || mean !== want_mean || variance !== want_var) begin
        errors++;
        $display("FAIL ramp_stall cyc %0d got ov=%b ir=%b m=%h v=%h want ov=1 ir=0 m=%h v=%h",
                 i, out_valid, in_ready, mean, variance, want_mean, want_var);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_release out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ramp_release in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_random_gaps();
    int accepted;
    fill_random();
    model();
    accepted = 0;
    for (int i = 0; i < N; i++) begin
      while ($urandom_range(99) < 40) begin
        in_valid = 1'b0;
        data_in  = $urandom;
        step();
        checks++;
        if (beat_count !== LN'(accepted)) begin
          errors++; $display("FAIL gap_idle_count got %0d want %0d", beat_count, accepted);
        end
      end
      in_valid = 1'b1;
      data_in  = frame_data[i];
      step();
      accepted = (accepted + 1) % N;
      in_valid = 1'b0;
      checks++;
      if (beat_count !== LN'(accepted)) begin
        errors++; $display("FAIL gap_beat_count got %0d want %0d", beat_count, accepted);
      end
    end
    step();
    step();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_out_valid got %b want 1", out_valid); end
    if (mean !== exp_mean) begin errors++; $display("FAIL gap_mean got %h want %h", mean, exp_mean); end
    if (variance !== exp_var) begin errors++; $display("FAIL gap_var got %h want %h", variance, exp_var); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      model();
      send_frame(0);
      step();
      step();
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid f%0d got %b want 1", f, out_valid); end
      if (mean !== exp_mean) begin errors++; $display("FAIL b2b_mean f%0d got %h want %h", f, mean, exp_mean); end
      if (variance !== exp_var) begin errors++; $display("FAIL b2b_var f%0d got %h want %h", f, variance, exp_var); end
      step();
    end
  endtask

  task automatic test_clear();
    logic [CH*W-1:0]   held_mean;
    logic [CH*2*W-1:0] held_var;
    held_mean = exp_mean;
    held_var  = exp_var;
    fill_random();
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      data_in  = frame_data[i];
      step();
    end
    in_valid = 1'b1;
    clear    = 1'b1;
    data_in  = {CH{8'd200}};
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    checks += 4;
    if (beat_count !== '0) begin errors++; $display("FAIL clear_beat_count got %0d want 0", beat_count); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_out_valid got %b want 0", out_valid); end
    if (mean !== held_mean) begin errors++; $display("FAIL clear_mean_held got %h want %h", mean, held_mean); end
    if (variance !== held_var) begin errors++; $display("FAIL clear_var_held got %h want %h", variance, held_var); end
    fill_const(8'd7);
    send_frame(10);
    step();
    step();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL clear_next_out_valid got %b want 1", out_valid); end
    if (mean !== {CH{8'd7}}) begin errors++; $display("FAIL clear_next_mean got %h want %h", mean, {CH{8'd7}}); end
    if (variance !== '0) begin errors++; $display("FAIL clear_next_var got %h want 0", variance); end
    step();
  endtask

  task automatic test_reset_in_out();
    out_ready = 1'b0;
    fill_random();
    send_frame(0);
    step();
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rout_reach_out got %b want 1", out_valid); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rout_out_valid got %b want 0", out_valid); end
    if (mean !== '0) begin errors++; $display("FAIL rout_mean got %h want 0", mean); end
    if (variance !== '0) begin errors++; $display("FAIL rout_var got %h want 0", variance); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rout_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_accum();
    fill_random();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      data_in  = frame_data[i];
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    step();
    reset    = 1'b1;
    checks++;
    if (beat_count !== '0) begin errors++; $display("FAIL racc_beat_count got %0d want 0", beat_count); end
    fill_random();
    model();
    send_frame(20);
    step();
    step();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL racc_out_valid got %b want 1", out_valid); end
    if (mean !== exp_mean) begin errors++; $display("FAIL racc_mean got %h want %h", mean, exp_mean); end
    if (variance !== exp_var) begin errors++; $display("FAIL racc_var got %h want %h", variance, exp_var); end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
    step();
    test_reset();
    test_constant();
    test_ramp_stall();
    test_random_gaps();
    test_back_to_back();
    test_clear();
    test_reset_in_out();
    test_reset_mid_accum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/variance_stream_mc.md
Name: variance_stream_mc

Overview:
- Multi-channel streaming successor to the single-channel variance block.
- Accepts CHANNELS parallel unsigned pixel lanes per beat over a frame of INPUT_NUM beats.
- Produces per-channel mean and population variance once per frame.
- Uses valid/ready handshakes on both input and output.
- Sits between the pixel feeder and the normalisation stage of the CNN front end.

Parameters:
- WIDTH, 8, bits per channel sample (unsigned).
- CHANNELS, 4, number of parallel lanes.
- IMG_WIDTH, 8, frame width in beats.
- IMG_HEIGHT, 8, frame height in beats.
- INPUT_NUM, IMG_WIDTH*IMG_HEIGHT, beats per frame.
- LOG2_N, 6, log2(INPUT_NUM). 2**LOG2_N must equal INPUT_NUM; the implementation fails elaboration otherwise.

Ports:
- clk, in, 1: single clock, all logic on its rising edge.
- reset, in, 1: synchronous, active-low. Sampled on rising clk; 0 resets.
- clear, in, 1: synchronous frame abort, active-high.
- in_valid, in, 1: data_in beat valid.
- in_ready, out, 1: block accepts a beat. A beat transfers when in_valid && in_ready.
- data_in, in, CHANNELS*WIDTH: lane c occupies bits [c*WIDTH +: WIDTH].
- out_valid, out, 1: mean and variance hold a completed frame result.
- out_ready, in, 1: consumer accepts the result.
- mean, out, CHANNELS*WIDTH: per-lane floor(sum/INPUT_NUM).
- variance, out, CHANNELS*2*WIDTH: per-lane population variance, lane c at [c*2*WIDTH +: 2*WIDTH].
- beat_count, out, LOG2_N: beats accepted in the current frame.

Behaviour:
- Reset (reset==0 at a rising edge), applied from any state: state=ACCUM, beat_count=0, all accumulators=0, mean=0, variance=0, out_valid=0, in_ready=1.
- Per-lane accumulators:
  - sum: WIDTH+LOG2_N bits.
  - sumsq: 2*WIDTH+LOG2_N bits.
  - Neither can overflow at the maximum input value.
- FSM states: ACCUM, CALC1, CALC2, OUT.
- ACCUM:
  - in_ready=1.
  - On each transfer: sum+=x, sumsq+=x*x for every lane, beat_count++.
  - On the transfer where beat_count==INPUT_NUM-1: beat_count wraps to 0 and the FSM goes to CALC1.
- CALC1:
  - in_ready=0.
  - Register per lane: mean_r=sum>>LOG2_N and ex2_r=sumsq>>LOG2_N (2*WIDTH bits).
  - Zero sum and sumsq.
  - Go to CALC2.
- CALC2:
  - in_ready=0.
  - variance=ex2_r-mean_r*mean_r (2*WIDTH bits); drive mean=mean_r.
  - Set out_valid=1 and go to OUT.
  - The result is never negative because floor(mean)^2 <= floor(E[x^2]), so no saturation logic is required.
- OUT:
  - in_ready=0.
  - out_valid stays 1, and mean/variance stay stable, until out_ready==1 at a rising edge.
  - On that edge: out_valid=0 and the FSM returns to ACCUM.
  - If out_ready is already high, out_valid is high for exactly one cycle.
- Latency:
  - The last beat is accepted at edge k; out_valid rises at edge k+2.
  - Minimum frame period is INPUT_NUM+3 cycles.
- clear==1 (reset high), in any state:
  - Next state ACCUM, beat_count=0, accumulators=0, out_valid=0.
  - mean/variance keep their last values.
  - clear wins over a simultaneous transfer; that beat is discarded.
- in_valid low in ACCUM: nothing changes (gaps in the input stream are allowed).
- data_in is ignored whenever in_ready==0.

Test Plan:
- Reset, then 64 beats with all lanes=5 -> out_valid 2 cycles after the last beat; mean=5 and variance=0 on every lane.
- 64 beats, lane0 ramp 0..63, lane1 alternating 0/255, lane2=255, lane3=0 -> lane0 mean=31 var=372; lane1 mean=127 var=16383; lane2 mean=255 var=0; lane3 mean=0 var=0.
- Ramp frame with out_ready held 0 for 10 cycles -> out_valid and results stable for the whole stall; in_ready=0 throughout; the frame completes one cycle after out_ready rises.
- in_valid toggled randomly during a frame -> results identical to the gapless frame; beat_count increments only on transfers.
- Assert clear after 30 beats, with in_valid=1 on the same cycle -> beat_count=0 and that beat is discarded; a following 64-beat constant-7 frame yields mean=7, var=0.
- Drive reset=0 for one cycle during OUT -> out_valid=0, mean=0, variance=0, in_ready=1 on the next cycle.
- Drive reset=0 for one cycle mid-ACCUM -> next frame unaffected by the aborted partial sums.
